// File: rtl/pgm_rom_ddram_loader.sv
// Packs the 16-bit hps_io ROM download stream into 64-bit DDRAM beats,
// buffers them in a small FIFO and writes them out one beat at a time.
module pgm_rom_ddram_loader #(
    parameter logic [7:0]  ROM_INDEX  = 8'h00,
    parameter logic [28:0] BASE_ADDR  = 29'h0000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        fixed_50m_clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic [3:0]  ddram_burstcnt,
    input  logic        ddram_busy,
    output logic        load_busy,
    output logic        load_done,
    output logic        overflow,
    output logic [23:0] beats_written
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_WAIT = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [63:0]   acc_din, acc_din_n;
    logic [7:0]    acc_be, acc_be_n;
    logic [23:0]   acc_tag;
    logic          flush_pend;
    logic [100:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          word_ok, end_load, push, push_ok, pop;
    logic [1:0]    lane;
    logic [23:0]   tag;
    logic          unused_bits;

    assign unused_bits = ioctl_addr[0];

    always_comb begin
        word_ok    = (state == S_LOAD) && ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
        lane       = ioctl_addr[2:1];
        tag        = ioctl_addr[26:3];
        end_load   = (state == S_LOAD) && !ioctl_download;
        // A flush and a new word can share a cycle: the old beat leaves, the word starts a fresh one.
        push       = (|acc_be) && (flush_pend || end_load || (word_ok && (tag != acc_tag)));
        pop        = (count != '0) && !ddram_busy;
        push_ok    = push && ((count != CNT_MAX) || pop);
        count_next = count + CW'(push_ok) - CW'(pop);
        acc_be_n   = push ? 8'h00 : acc_be;
        acc_din_n  = push ? 64'h0 : acc_din;
        if (word_ok) begin
            acc_be_n[{lane, 1'b0} +: 2]     = 2'b11;
            acc_din_n[{lane, 4'b0000} +: 16] = ioctl_dout;
        end
    end

    assign ddram_we       = (count != '0);
    assign ddram_addr     = ddram_we ? fifo_mem[rd_ptr][100:72] : 29'h0;
    assign ddram_din      = ddram_we ? fifo_mem[rd_ptr][71:8]   : 64'h0;
    assign ddram_be       = ddram_we ? fifo_mem[rd_ptr][7:0]    : 8'h00;
    assign ddram_burstcnt = 4'd1;
    assign ioctl_wait     = (count >= CNT_WAIT);

    always_ff @(posedge fixed_50m_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= {BASE_ADDR + 29'(acc_tag), acc_din, acc_be};
    end

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            acc_din       <= '0;
            acc_be        <= '0;
            acc_tag       <= '0;
            flush_pend    <= 1'b0;
            load_busy     <= 1'b0;
            load_done     <= 1'b0;
            overflow      <= 1'b0;
            beats_written <= '0;
        end else begin
            load_done <= 1'b0;
            acc_din   <= acc_din_n;
            acc_be    <= acc_be_n;
            if (push && !push_ok) overflow <= 1'b1;
            if (pop && (beats_written != 24'hFFFFFF)) beats_written <= beats_written + 24'd1;
            if (word_ok) begin
                acc_tag    <= tag;
                flush_pend <= (lane == 2'd3);
            end else if (push) begin
                flush_pend <= 1'b0;
            end
            case (state)
                S_IDLE: if (ioctl_download && (ioctl_index == ROM_INDEX)) begin
                    state         <= S_LOAD;
                    load_busy     <= 1'b1;
                    beats_written <= '0;
                end
                S_LOAD: if (!ioctl_download) state <= S_DRAIN;
                S_DRAIN: if (count_next == '0) begin
                    state     <= S_DONE;
                    load_done <= 1'b1;
                    load_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_rom_ddram_loader.sv
// Bench for pgm_rom_ddram_loader: directed scenarios plus random loads checked
// against a word-sequence model of the beat packing rules.
module tb_pgm_rom_ddram_loader;

    typedef struct packed {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } beat_t;

    localparam logic [28:0] BASE = 29'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [3:0]  ddram_burstcnt;
    logic        ddram_busy = 1'b0;
    logic        load_busy, load_done, overflow;
    logic [23:0] beats_written;

    always #5 clk = ~clk;

    pgm_rom_ddram_loader dut (
        .fixed_50m_clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
        .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_burstcnt(ddram_burstcnt),
        .ddram_busy(ddram_busy), .load_busy(load_busy), .load_done(load_done),
        .overflow(overflow), .beats_written(beats_written)
    );

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [26:0] w_addr[$];
    logic [15:0] w_data[$];
    int total = 0, bad = 0;
    int done_cnt = 0, stall_bad = 0, wait_cnt = 0, busy_cnt = 0;
    bit rand_busy = 0;
    bit prev_stall = 0;
    beat_t prev_beat;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (ddram_we !== 1'b1 || {ddram_addr, ddram_din, ddram_be} !== prev_beat))
                stall_bad <= stall_bad + 1;
            prev_stall <= ddram_we && ddram_busy;
            prev_beat  <= {ddram_addr, ddram_din, ddram_be};
            if (ddram_we && !ddram_busy) got_q.push_back(beat_t'({ddram_addr, ddram_din, ddram_be}));
            if (load_done)  done_cnt <= done_cnt + 1;
            if (load_busy)  busy_cnt <= busy_cnt + 1;
            if (ioctl_wait) wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_busy) ddram_busy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send_word(input logic [26:0] a, input logic [15:0] d);
        int t = 0;
        while (ioctl_wait && t < 300) begin tick(); t++; end
        if (t >= 300) begin
            total++; bad++;
            $display("FAIL wait_timeout: ioctl_wait=%b still high, required low within 300 cycles", ioctl_wait);
        end
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx; ioctl_download = 1'b1;
        tick(); tick();
    endtask

    // Beats expected from the word list: a beat closes when the tag changes,
    // when lane 3 is written, or at the end of the download.
    task automatic model_load();
        logic [23:0] t; logic [63:0] d; logic [7:0] be; bit v;
        int lane;
        t = '0; d = '0; be = '0; v = 0;
        foreach (w_addr[i]) begin
            lane = int'(w_addr[i][2:1]);
            if (v && w_addr[i][26:3] != t) begin
                exp_q.push_back('{BASE + 29'(t), d, be}); d = '0; be = '0; v = 0;
            end
            t = w_addr[i][26:3];
            d[lane*16 +: 16] = w_data[i];
            be[lane*2 +: 2]  = 2'b11;
            v = 1;
            if (lane == 3) begin
                exp_q.push_back('{BASE + 29'(t), d, be}); d = '0; be = '0; v = 0;
            end
        end
        if (v) exp_q.push_back('{BASE + 29'(t), d, be});
    endtask

    task automatic run_load(input string name);
        int g0 = got_q.size();
        int e0 = exp_q.size();
        int d0 = done_cnt;
        int n, t;
        start_dl(8'h00);
        foreach (w_addr[i]) send_word(w_addr[i], w_data[i]);
        ioctl_download = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 500) begin tick(); t++; end
        total++;
        if (done_cnt == d0) begin bad++; $display("FAIL %s_done: no load_done within 500 cycles", name); end
        model_load();
        n = exp_q.size() - e0;
        total++;
        if (got_q.size() - g0 != n) begin
            bad++; $display("FAIL %s_count: got %0d beats, required %0d", name, got_q.size() - g0, n);
        end
        for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[e0+i]) begin
                bad++;
                $display("FAIL %s_beat%0d: got a=%h d=%h be=%h, required a=%h d=%h be=%h", name, i,
                         got_q[g0+i].a, got_q[g0+i].d, got_q[g0+i].be,
                         exp_q[e0+i].a, exp_q[e0+i].d, exp_q[e0+i].be);
            end
        end
        total++;
        if (beats_written !== 24'(n)) begin
            bad++; $display("FAIL %s_beats_written: got %0d, required %0d", name, beats_written, n);
        end
        tick(); tick();
        total++;
        if (load_busy !== 1'b0 || done_cnt != d0 + 1) begin
            bad++; $display("FAIL %s_finish: load_busy=%b done_pulses=%0d, required 0 and 1", name, load_busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({ddram_we, ddram_addr, ddram_din, ddram_be, load_busy, load_done, overflow, beats_written, ioctl_wait} !== '0
            || ddram_burstcnt !== 4'd1) begin
            bad++; $display("FAIL reset_outputs: we=%b busy=%b done=%b ovf=%b bw=%0d wait=%b burst=%0d, required zeros and burst 1",
                            ddram_we, load_busy, load_done, overflow, beats_written, ioctl_wait, ddram_burstcnt);
        end
    endtask

    task automatic test_contiguous();
        int g0 = got_q.size();
        w_addr.delete(); w_data.delete();
        for (int i = 0; i < 8; i++) begin
            w_addr.push_back(27'(2 * i));
            w_data.push_back(16'($urandom));
        end
        run_load("contig");
        total++;
        if (got_q.size() >= g0 + 2) begin
            if (got_q[g0].a !== 29'd0 || got_q[g0].be !== 8'hFF || got_q[g0].d !== {w_data[3], w_data[2], w_data[1], w_data[0]}
                || got_q[g0+1].a !== 29'd1 || got_q[g0+1].d !== {w_data[7], w_data[6], w_data[5], w_data[4]}) begin
                bad++; $display("FAIL contig_fixed: got a0=%h be0=%h d0=%h a1=%h d1=%h", got_q[g0].a, got_q[g0].be,
                                got_q[g0].d, got_q[g0+1].a, got_q[g0+1].d);
            end
        end else begin
            bad++; $display("FAIL contig_fixed: got %0d beats, required 2", got_q.size() - g0);
        end
    endtask

    task automatic test_partial();
        int g0 = got_q.size();
        w_addr.delete(); w_data.delete();
        w_addr.push_back(27'h12); w_data.push_back(16'hBEEF);
        run_load("partial");
        total++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== beat_t'({29'd2, 64'h00000000BEEF0000, 8'h0C})) begin
            bad++; $display("FAIL partial_fixed: got %0d beats, first a=%h d=%h be=%h; required a=2 d=BEEF0000 be=0C",
                            got_q.size() - g0, got_q[g0].a, got_q[g0].d, got_q[g0].be);
        end
    endtask

    task automatic test_discontinuity();
        int g0 = got_q.size();
        w_addr.delete(); w_data.delete();
        w_addr.push_back(27'h000); w_data.push_back(16'h1234);
        w_addr.push_back(27'h100); w_data.push_back(16'h5678);
        run_load("discont");
        total++;
        if (got_q.size() != g0 + 2 || got_q[g0].a !== 29'h0 || got_q[g0].be !== 8'h03
            || got_q[g0+1].a !== 29'h20 || got_q[g0+1].be !== 8'h03) begin
            bad++; $display("FAIL discont_fixed: got %0d beats a0=%h be0=%h a1=%h be1=%h; required 0/03 and 20/03",
                            got_q.size() - g0, got_q[g0].a, got_q[g0].be, got_q[g0+1].a, got_q[g0+1].be);
        end
    endtask

    task automatic test_backpressure();
        int g0 = got_q.size();
        int e0 = exp_q.size();
        int d0 = done_cnt;
        int s0 = stall_bad;
        int n, t;
        w_addr.delete(); w_data.delete();
        for (int i = 0; i < 24; i++) begin
            w_addr.push_back(27'(2 * i));
            w_data.push_back(16'($urandom));
        end
        ddram_busy = 1'b1;
        fork
            begin
                repeat (40) tick();
                total++;
                if (ioctl_wait !== 1'b1 || got_q.size() != g0) begin
                    bad++; $display("FAIL bp_stalled: ioctl_wait=%b writes=%0d, required 1 and 0", ioctl_wait, got_q.size() - g0);
                end
                ddram_busy = 1'b0;
            end
            begin
                start_dl(8'h00);
                foreach (w_addr[i]) send_word(w_addr[i], w_data[i]);
            end
        join
        ioctl_download = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 500) begin tick(); t++; end
        model_load();
        n = exp_q.size() - e0;
        total++;
        if (got_q.size() - g0 != 6) begin
            bad++; $display("FAIL bp_count: got %0d beats, required 6", got_q.size() - g0);
        end
        for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[e0+i]) begin
                bad++; $display("FAIL bp_beat%0d: got a=%h d=%h, required a=%h d=%h", i,
                                got_q[g0+i].a, got_q[g0+i].d, exp_q[e0+i].a, exp_q[e0+i].d);
            end
        end
        total++;
        if (overflow !== 1'b0 || stall_bad != s0 || done_cnt != d0 + 1) begin
            bad++; $display("FAIL bp_status: overflow=%b unstable=%0d done=%0d, required 0 0 1", overflow, stall_bad - s0, done_cnt - d0);
        end
        tick(); tick();
    endtask

    task automatic test_filter();
        int g0 = got_q.size();
        int b0 = busy_cnt;
        start_dl(8'h01);
        for (int i = 0; i < 8; i++) send_word(27'(2 * i), 16'($urandom));
        ioctl_download = 1'b0;
        repeat (20) tick();
        total++;
        if (got_q.size() != g0 || busy_cnt != b0 || ddram_we !== 1'b0) begin
            bad++; $display("FAIL filter: writes=%0d busy_cycles=%0d we=%b, required 0 0 0", got_q.size() - g0, busy_cnt - b0, ddram_we);
        end
        ioctl_index = 8'h00;
    endtask

    task automatic test_random();
        int n, k;
        bit seq;
        rand_busy = 1;
        for (int l = 0; l < 4; l++) begin
            w_addr.delete(); w_data.delete();
            n = $urandom_range(1, 20);
            k = $urandom_range(0, 15);
            seq = $urandom_range(0, 1) == 1;
            for (int i = 0; i < n; i++) begin
                w_addr.push_back(27'(2 * (seq ? k + i : $urandom_range(0, 31))));
                w_data.push_back(16'($urandom));
            end
            run_load("random");
        end
        rand_busy = 0;
        ddram_busy = 1'b0;
        tick();
        total++;
        if (overflow !== 1'b0 || stall_bad != 0) begin
            bad++; $display("FAIL random_status: overflow=%b unstable=%0d, required 0 0", overflow, stall_bad);
        end
    endtask

    task automatic test_reset_mid();
        ddram_busy = 1'b1;
        start_dl(8'h00);
        for (int i = 0; i < 4; i++) send_word(27'(2 * i), 16'($urandom));
        tick(); tick();
        total++;
        if (ddram_we !== 1'b1) begin bad++; $display("FAIL rst_pre: ddram_we=%b, required 1", ddram_we); end
        #2;
        reset_n = 1'b0; ioctl_download = 1'b0;
        #1;
        total++;
        if (ddram_we !== 1'b0 || beats_written !== 24'd0 || load_busy !== 1'b0 || ioctl_wait !== 1'b0) begin
            bad++; $display("FAIL rst_async: we=%b bw=%0d busy=%b wait=%b, required all 0", ddram_we, beats_written, load_busy, ioctl_wait);
        end
        tick();
        reset_n = 1'b1; ddram_busy = 1'b0;
        tick(); tick();
        w_addr.delete(); w_data.delete();
        for (int i = 0; i < 6; i++) begin
            w_addr.push_back(27'(16'h40 + 2 * i));
            w_data.push_back(16'($urandom));
        end
        run_load("after_rst");
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        reset_n = 1'b1;
        tick(); tick();
        test_reset();
        test_contiguous();
        test_partial();
        test_discontinuity();
        test_backpressure();
        test_filter();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pgm_rom_ddram_loader.md
Name: pgm_rom_ddram_loader

Overview:
- Upstream feeder for the PGM core's DDRAM-resident ROM area.
- Consumes the 16-bit hps_io ioctl download stream and packs the words into 64-bit DDRAM beats with byte enables.
- Buffers beats in a small FIFO and issues single-beat DDRAM writes, honouring ddram_busy backpressure.
- Throttles the HPS with ioctl_wait; signals completion so the core can leave reset after the ROM image is fully committed.

Parameters:
- ROM_INDEX, 8'h00, ioctl_index value accepted; other indices are ignored.
- BASE_ADDR, 29'h0000000, DDRAM 64-bit word address of ROM byte 0.
- FIFO_DEPTH, 4, beat FIFO entries; power of two, ≥2.

Ports:
- fixed_50m_clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle word strobe.
- ioctl_addr  in  27  byte address of the word; bit0 always 0.
- ioctl_dout  in  16  download data word.
- ioctl_wait  out  1  request to the HPS to pause strobes.
- ddram_we  out  1  write request.
- ddram_addr  out  29  64-bit word address.
- ddram_din  out  64  write data.
- ddram_be  out  8  byte enables.
- ddram_burstcnt  out  4  constant 4'd1.
- ddram_busy  in  1  stall; a write is accepted on a cycle with ddram_we=1 and ddram_busy=0.
- load_busy  out  1  high from accepted download start until DONE.
- load_done  out  1  one-cycle pulse when the last beat is accepted.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- beats_written  out  24  count of accepted DDRAM beats for the current load.

Behaviour:
- Reset (async): all outputs 0 except ddram_burstcnt=1.
  - FIFO, accumulator, state and counters cleared.
  - An in-flight write is abandoned; ddram_we falls immediately.
- Word qualification: a word is accepted when ioctl_wr=1, ioctl_download=1 and ioctl_index==ROM_INDEX.
- Lane mapping: lane = ioctl_addr[2:1].
  - Data goes to acc_din[lane*16+:16], unchanged, with no byte swap.
  - Sets acc_be[2*lane+:2].
  - Beat tag = ioctl_addr[26:3].
- Accumulator flush: pushes {BASE_ADDR+tag, acc_din, acc_be} to the FIFO, then clears acc_be and acc_din.
  - (a) A word lands in lane 3: pushed the cycle after, including that word.
  - (b) An accepted word has a tag different from the valid accumulator's tag: the old beat is pushed and the new word starts a fresh accumulator in the same cycle.
  - (c) The download ends with a non-empty accumulator.
- Rewriting an already-set lane within the same beat overwrites the data; be is unchanged.
- ioctl_wait = (fifo_count ≥ FIFO_DEPTH−1). This guarantees room for a flush plus a lane-3 push.
- If a push finds the FIFO full, the beat is dropped and overflow is set until reset.
- Write port:
  - Head entry is presented on ddram_addr/din/be with ddram_we=1 whenever the FIFO is non-empty.
  - The outputs stay stable while busy=1.
  - On acceptance the entry is popped and beats_written increments.
  - If another entry exists, it is presented on the next cycle with ddram_we held high (one beat per cycle at best).
- State machine:
  - IDLE→LOAD on a rising edge of ioctl_download with a matching index; clears beats_written and sets load_busy.
  - LOAD→DRAIN when ioctl_download falls; the partial accumulator is flushed on the transition cycle.
  - DRAIN→DONE when the FIFO is empty and no write is pending.
  - DONE: load_done=1 for one cycle, load_busy falls, →IDLE.
  - A download for another index leaves the block in IDLE with no writes.
  - If a new matching download starts during DRAIN, DRAIN completes first.
  - If ioctl_download re-rises in DONE, the block goes to IDLE then LOAD on the next edge.
- Latency: from the lane-3 word strobe to ddram_we is 2 cycles with an empty FIFO.
- beats_written saturates at 24'hFFFFFF.

Test Plan:
- Contiguous burst: 8 words w0..w7 at addr 0,2,…,14, busy=0.
  - Expect two writes: addr 0, be FF, din {w3,w2,w1,w0}; then addr 1, din {w7..w4}.
  - Then download falls: load_done pulses, beats_written=2.
- Partial beat: one word 16'hBEEF at addr 0x12, then download falls.
  - Expect one write: addr 2, be 8'h0C, din[31:16]=BEEF, other bits 0.
  - load_done follows acceptance.
- Backpressure: 24 contiguous words while busy held high 40 cycles.
  - ioctl_wait asserts once fifo_count reaches 3.
  - addr/din stay stable while busy.
  - After release, 6 beats are written in order, overflow=0.
- Discontinuity: word at addr 0x000, then word at addr 0x100.
  - Expect writes at addr 0 with be 03, then addr 0x20 with be 03.
- Filter: full download with ioctl_index=8'h01 → no ddram_we, load_busy stays 0.
- Reset mid-operation: reset_n low while ddram_we=1 and busy=1.
  - ddram_we falls asynchronously; beats_written=0, state IDLE; the next download behaves normally.
